// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if
//   Parallel output bundle of the UART receiver.
//   master : driven by uart_rx_deserializer
//   slave  : consumed by downstream logic
//   p_data      last good byte, held until the next good frame
//   data_valid  1-cycle strobe, p_data just updated
//   framing_err 1-cycle strobe, stop bit sampled low
//   parity_err  1-cycle strobe, parity mismatch
//   busy        receiver is inside a frame
interface uart_rx_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  framing_err;
  logic                  parity_err;
  logic                  busy;

  modport master (
    output p_data, data_valid, framing_err, parity_err, busy
  );

  modport slave (
    input p_data, data_valid, framing_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   Receive side of the UART link. Runs on the oversample clock, rebuilds
//   frames of start(0), DATA_WIDTH data bits MSB first, optional parity,
//   one stop(1), and presents them as a parallel byte with a valid strobe.
//   Optional feature macro: UART_RX_PARITY_EN (adds the parity bit/state).
// Ports
//   clk     in  oversample clock, rising edge
//   rst     in  synchronous reset, active low
//   rx_in   in  serial line, idle high, asynchronous to clk
//   rx_bus  master modport: p_data, data_valid, framing_err, parity_err, busy
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | qualifying start bit, glitch returns to IDLE
// DATA   | sampling data bits, MSB first
// PARITY | sampling parity bit (UART_RX_PARITY_EN only)
// STOP   | stop bit decided half a bit early so the next start edge is caught
// BREAK  | stop bit was low, wait for line high before re-arming
module uart_rx_deserializer #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_in,
  uart_rx_deserializer_if.master rx_bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_t;

  state_t                state;
  logic                  rx_m, rx_s;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [1:0]            samp;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q, framing_err_q, parity_err_q, busy_q;
  logic                  maj;
  logic                  par_fault_now;

  // Two samples are stored, the third is the live rx_s at tick OVERSAMPLE/2+1,
  // so the vote is ready exactly on the decision tick.
  always_comb begin
    maj = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  end

`ifdef UART_RX_PARITY_EN
  logic par_fault;
  assign par_fault_now = par_fault;
`else
  logic unused_cfg;
  assign unused_cfg    = PARITY_ODD[0];
  assign par_fault_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      samp          <= '0;
      shift_reg     <= '0;
      p_data_q      <= '0;
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
      busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_fault     <= 1'b0;
`endif
    end else begin
      rx_m          <= rx_in;
      rx_s          <= rx_m;
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      parity_err_q  <= 1'b0;

      if (state inside {START, DATA, PARITY, STOP}) begin
        tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
        if (tick_cnt == T_S0) samp[0] <= rx_s;
        if (tick_cnt == T_S1) samp[1] <= rx_s;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            busy_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_fault <= 1'b0;
`endif
          end
        end

        START: begin
          if (tick_cnt == T_S2 && maj) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (tick_cnt == T_LAST) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (tick_cnt == T_S2) shift_reg <= {shift_reg[DATA_WIDTH-2:0], maj};
          if (tick_cnt == T_LAST) begin
            if (bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt == T_S2) par_fault <= (maj != (^shift_reg ^ PARITY_ODD[0]));
          if (tick_cnt == T_LAST) state <= STOP;
        end
`endif

        STOP: begin
          if (tick_cnt == T_S2) begin
            if (maj) begin
              if (par_fault_now) begin
                parity_err_q <= 1'b1;
              end else begin
                p_data_q     <= shift_reg;
                data_valid_q <= 1'b1;
              end
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              framing_err_q <= 1'b1;
              state         <= BREAK;
            end
          end
        end

        BREAK: begin
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_bus.p_data      = p_data_q;
  assign rx_bus.data_valid  = data_valid_q;
  assign rx_bus.framing_err = framing_err_q;
  assign rx_bus.parity_err  = parity_err_q;
  assign rx_bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer. The serial line of each phase is built as
// one sample per clock, a frame-level model derives the expected outputs for
// every cycle, and the line is then played into the DUT after a reset.
module tb_uart_rx_deserializer;
  localparam int OS   = 8;
  localparam int DW   = 8;
  localparam int H    = OS / 2;
  localparam int MAXL = 8192;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_in = 1'b1;

  uart_rx_deserializer_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_deserializer #(
    .OVERSAMPLE(OS), .DATA_WIDTH(DW), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_bus(bus)
  );

  always #5 clk = ~clk;

  bit          line    [MAXL];
  int          len;
  bit          e_valid [MAXL];
  bit          e_ferr  [MAXL];
  bit          e_perr  [MAXL];
  bit          e_busy  [MAXL];
  logic [DW-1:0] e_vdata [MAXL];
  logic [DW-1:0] e_pdata [MAXL];

  int checks = 0;
  int errors = 0;
  int n_valid, n_ferr, n_perr;
  logic [DW-1:0] first_valid_data;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- line builder ----------------
  task automatic put(bit v, int cnt);
    for (int i = 0; i < cnt; i++) if (len < MAXL) begin line[len] = v; len++; end
  endtask

  // Noise only away from the three voting samples of the bit.
  task automatic put_bit(bit v, bit noisy);
    for (int k = 0; k < OS; k++) begin
      bit x;
      x = v;
      if (noisy && (k < H || k > H + 2) && $urandom_range(3) == 0) x = ~v;
      if (len < MAXL) begin line[len] = x; len++; end
    end
  endtask

  task automatic add_frame(logic [DW-1:0] d, bit stop, bit par_flip, bit noisy);
    put(1'b0, OS);
    for (int i = DW - 1; i >= 0; i--) put_bit(d[i], noisy);
    if (PEN != 0) put_bit((^d) ^ PODD ^ par_flip, noisy);
    put(stop, OS);
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit samp(int i);
    if (i < 0 || i >= len) return 1'b1;
    return line[i];
  endfunction

  // Vote for bit b of the frame whose start bit was first seen at sample n.
  function automatic bit maj3(int n, int b);
    int s;
    s = samp(n + OS * b + H) + samp(n + OS * b + H + 1) + samp(n + OS * b + H + 2);
    return s >= 2;
  endfunction

  task automatic mark_busy(int lo, int hi);
    for (int e = lo; e < hi; e++) if (e >= 0 && e < MAXL) e_busy[e] = 1'b1;
  endtask

  // A line sample presented before edge i is seen by the FSM at edge i+2
  // (two synchronizer flops); outputs decided at edge e are checked after e.
  task automatic build_model();
    int idx, n, s, dec, m;
    logic [DW-1:0] d;
    bit pf;
    logic [DW-1:0] cur;
    for (int i = 0; i < MAXL; i++) begin
      e_valid[i] = 1'b0; e_ferr[i] = 1'b0; e_perr[i] = 1'b0; e_busy[i] = 1'b0;
      e_vdata[i] = '0;
    end
    idx = 0;
    while (idx < len) begin
      if (samp(idx)) begin
        idx++;
        continue;
      end
      n = idx;
      if (maj3(n, 0)) begin
        mark_busy(n + 2, n + H + 4);
        idx = n + H + 3;
        continue;
      end
      d = '0;
      for (int j = 0; j < DW; j++) d = {d[DW-2:0], maj3(n, 1 + j)};
      pf = 1'b0;
      s = 1 + DW;
      if (PEN != 0) begin
        pf = maj3(n, 1 + DW) != ((^d) ^ PODD);
        s = 2 + DW;
      end
      dec = n + OS * s + H + 4;
      if (maj3(n, s)) begin
        mark_busy(n + 2, dec);
        if (dec < MAXL) begin
          if (pf) e_perr[dec] = 1'b1;
          else begin e_valid[dec] = 1'b1; e_vdata[dec] = d; end
        end
        idx = n + OS * s + H + 3;
      end else begin
        if (dec < MAXL) e_ferr[dec] = 1'b1;
        m = n + OS * s + H + 3;
        while (m < len && !samp(m)) m++;
        mark_busy(n + 2, m + 2);
        idx = m + 1;
      end
    end
    cur = '0;
    for (int e = 0; e < MAXL; e++) begin
      if (e_valid[e]) cur = e_vdata[e];
      e_pdata[e] = cur;
    end
  endtask

  // ---------------- player / compare ----------------
  task automatic run_phase(string tag);
    build_model();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rst_pdata"}, int'(bus.p_data), 0);
    check({tag, "_rst_valid"}, int'(bus.data_valid), 0);
    check({tag, "_rst_ferr"},  int'(bus.framing_err), 0);
    check({tag, "_rst_perr"},  int'(bus.parity_err), 0);
    check({tag, "_rst_busy"},  int'(bus.busy), 0);
    rst = 1'b1;
    rx_in = line[0];
    n_valid = 0; n_ferr = 0; n_perr = 0;
    first_valid_data = '0;
    for (int e = 0; e < len; e++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_valid"}, int'(bus.data_valid),  int'(e_valid[e]));
      check({tag, "_ferr"},  int'(bus.framing_err), int'(e_ferr[e]));
      check({tag, "_perr"},  int'(bus.parity_err),  int'(e_perr[e]));
      check({tag, "_busy"},  int'(bus.busy),        int'(e_busy[e]));
      check({tag, "_pdata"}, int'(bus.p_data),      int'(e_pdata[e]));
      if (bus.data_valid) begin
        if (n_valid == 0) first_valid_data = bus.p_data;
        n_valid++;
      end
      if (bus.framing_err) n_ferr++;
      if (bus.parity_err)  n_perr++;
      if (e + 1 < len) rx_in = line[e + 1];
    end
  endtask

  initial begin
    // Single good frame
    len = 0; put(1'b1, 5); add_frame(8'hA5, 1'b1, 1'b0, 1'b0); put(1'b1, 20);
    run_phase("a5");
    check("a5_nvalid", n_valid, 1);
    check("a5_nerr", n_ferr + n_perr, 0);
    check("a5_data", int'(bus.p_data), 8'hA5);
    check("a5_busy_end", int'(bus.busy), 0);

    // Back-to-back, zero idle
    len = 0; put(1'b1, 5);
    add_frame(8'h3C, 1'b1, 1'b0, 1'b0); add_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    put(1'b1, 20);
    run_phase("b2b");
    check("b2b_nvalid", n_valid, 2);
    check("b2b_first", int'(first_valid_data), 8'h3C);
    check("b2b_last", int'(bus.p_data), 8'hC3);

    // Start glitch after a good frame leaves p_data untouched
    len = 0; put(1'b1, 5); add_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    put(1'b1, 10); put(1'b0, 3); put(1'b1, 30);
    run_phase("glitch");
    check("glitch_nvalid", n_valid, 1);
    check("glitch_nerr", n_ferr + n_perr, 0);
    check("glitch_data", int'(bus.p_data), 8'h5A);
    check("glitch_busy_end", int'(bus.busy), 0);

    // Bad stop, line held low
    len = 0; put(1'b1, 5); add_frame(8'h55, 1'b0, 1'b0, 1'b0);
    put(1'b0, 40); put(1'b1, 20);
    run_phase("brk");
    check("brk_nferr", n_ferr, 1);
    check("brk_nvalid", n_valid, 0);
    check("brk_nperr", n_perr, 0);
    check("brk_busy_end", int'(bus.busy), 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: even parity bit must be 1
    len = 0; put(1'b1, 5);
    add_frame(8'h07, 1'b1, 1'b1, 1'b0); put(1'b1, 10);
    add_frame(8'h07, 1'b1, 1'b0, 1'b0); put(1'b1, 20);
    run_phase("par");
    check("par_nperr", n_perr, 1);
    check("par_nvalid", n_valid, 1);
    check("par_data", int'(bus.p_data), 8'h07);
`endif

    // Good frame, then reset lands in the DATA bits of 0xFF
    len = 0; put(1'b1, 5); add_frame(8'h81, 1'b1, 1'b0, 1'b0); put(1'b1, 6);
    add_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    len = len - (DW + PEN - 3) * OS - OS;
    run_phase("pre_rst");
    check("pre_rst_data", int'(bus.p_data), 8'h81);
    check("pre_rst_busy", int'(bus.busy), 1);
    len = 0; put(1'b1, 5); add_frame(8'h12, 1'b1, 1'b0, 1'b0); put(1'b1, 20);
    run_phase("post_rst");
    check("post_rst_nvalid", n_valid, 1);
    check("post_rst_data", int'(bus.p_data), 8'h12);

    // Randomized frames with noise, random gaps, bad stops and bad parity
    len = 0; put(1'b1, 5);
    for (int f = 0; f < 40; f++) begin
      logic [DW-1:0] d;
      bit stop, pflip, noisy;
      d     = DW'($urandom);
      stop  = ($urandom_range(7) != 0);
      pflip = (PEN != 0) && ($urandom_range(3) == 0);
      noisy = $urandom_range(1) != 0;
      add_frame(d, stop, pflip, noisy);
      if (!stop) begin
        put(1'b0, $urandom_range(30));
        put(1'b1, 1 + $urandom_range(15));
      end else begin
        put(1'b1, $urandom_range(12));
      end
    end
    put(1'b1, 20);
    run_phase("rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
